life_next_gen: RTL and testbench



---
 rtl/life_next_gen.sv | 206 ++++++++++++++++++++
 tb/tb_life_next_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/life_next_gen.sv
// life_next_gen: streaming Game of Life generation engine.
// Takes one generation as row-major 16-bit words and emits the next
// generation in the same format, each word tagged with its DDR address.
// Three line buffers rotate by index; a buffer flagged in zero_buf reads as
// all-dead cells, which provides rows -1 and ROWS.
// Optional feature: define LIFE_WRAP_EN to wrap columns horizontally
// (column 0 and column 639 become neighbours). Undefined: edges are dead.
module life_next_gen #(
  parameter int WORDS_PER_ROW = 40,
  parameter int ROWS          = 480,
  parameter int ADDR_W        = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam int WW = $clog2(WORDS_PER_ROW + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_ROW - 1);
  localparam logic [WW-1:0] NUM_WORDS = WW'(WORDS_PER_ROW);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } state_t;

  state_t state;

  logic [15:0]   line_buf [3][WORDS_PER_ROW];
  logic [1:0]    prev_idx;
  logic [1:0]    cur_idx;
  logic [1:0]    next_idx;
  logic [2:0]    zero_buf;
  logic [RW-1:0] load_row;
  logic [RW-1:0] emit_row;
  logic [WW-1:0] load_word;
  logic [WW-1:0] emit_word;

  logic [WW-1:0] left_word;
  logic [WW-1:0] right_word;
  logic          left_ok;
  logic          right_ok;
  logic [1:0]    sel [3];
  logic [17:0]   ext [3];
  logic [3:0]    cnt;
  logic [15:0]   next_word;
  logic [8:0]    addr_row;
  logic [5:0]    addr_word;

  // Next-generation value of the word at emit_word, from the three buffered rows
  always_comb begin
    left_word  = (emit_word == '0) ? LAST_WORD : emit_word - 1'b1;
    right_word = (emit_word == LAST_WORD) ? '0 : emit_word + 1'b1;
`ifdef LIFE_WRAP_EN
    left_ok  = 1'b1;
    right_ok = 1'b1;
`else
    left_ok  = (emit_word != '0);
    right_ok = (emit_word != LAST_WORD);
`endif
    sel[0] = prev_idx;
    sel[1] = cur_idx;
    sel[2] = next_idx;
    for (int r = 0; r < 3; r++) begin
      ext[r] = '0;
      if (!zero_buf[sel[r]]) begin
        ext[r] = {right_ok & line_buf[sel[r]][right_word][0],
                  line_buf[sel[r]][emit_word],
                  left_ok & line_buf[sel[r]][left_word][15]};
      end
    end
    next_word = '0;
    cnt       = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = '0;
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          if (!(r == 1 && k == 1)) begin
            cnt = cnt + 4'(ext[r][i+k]);
          end
        end
      end
      next_word[i] = (cnt == 4'd3) || (ext[1][i+1] && (cnt == 4'd2));
    end
    addr_row  = 9'(emit_row);
    addr_word = 6'(emit_word);
  end

  // Line buffer write port: accepted input words land in the "next" buffer
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready) begin
      line_buf[next_idx][load_word] <= in_data;
    end
  end

  // Control FSM with registered handshake, data and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      load_row  <= '0;
      emit_row  <= '0;
      load_word <= '0;
      emit_word <= '0;
      prev_idx  <= 2'd0;
      cur_idx   <= 2'd1;
      next_idx  <= 2'd2;
      zero_buf  <= 3'b111;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            state     <= LOAD;
            in_ready  <= 1'b1;
            load_row  <= '0;
            load_word <= '0;
            prev_idx  <= 2'd0;
            cur_idx   <= 2'd1;
            next_idx  <= 2'd2;
            zero_buf  <= 3'b111;
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            zero_buf[next_idx] <= 1'b0;
            if (load_word == LAST_WORD) begin
              load_word <= '0;
              if (load_row == '0) begin
                prev_idx <= cur_idx;
                cur_idx  <= next_idx;
                next_idx <= prev_idx;
                load_row <= load_row + 1'b1;
              end else begin
                state     <= EMIT;
                in_ready  <= 1'b0;
                emit_row  <= load_row - 1'b1;
                emit_word <= '0;
              end
            end else begin
              load_word <= load_word + 1'b1;
            end
          end
        end
        EMIT: begin
          if (emit_word != NUM_WORDS) begin
            if (!out_valid || out_ready) begin
              out_valid <= 1'b1;
              out_data  <= next_word;
              out_addr  <= ADDR_W'({addr_row, addr_word});
              emit_word <= emit_word + 1'b1;
            end
          end else if (!out_valid || out_ready) begin
            out_valid <= 1'b0;
            emit_word <= '0;
            if (load_row != LAST_ROW) begin
              prev_idx  <= cur_idx;
              cur_idx   <= next_idx;
              next_idx  <= prev_idx;
              load_row  <= load_row + 1'b1;
              load_word <= '0;
              in_ready  <= 1'b1;
              state     <= LOAD;
            end else if (emit_row != LAST_ROW) begin
              prev_idx           <= cur_idx;
              cur_idx            <= next_idx;
              next_idx           <= prev_idx;
              zero_buf[prev_idx] <= 1'b1;
              emit_row           <= emit_row + 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_next_gen.sv
// tb_life_next_gen: directed bench for life_next_gen on a 640 x 24 field.
module tb_life_next_gen;

  localparam int WPR    = 40;
  localparam int NROWS  = 24;
  localparam int TOTAL  = WPR * NROWS;
  localparam int BUDGET = 20000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [23:0] out_addr;
  logic        busy;
  logic        done;

  logic [15:0] img  [TOTAL];
  logic [15:0] expd [TOTAL];
  int checks;
  int failures;
  int n_out;
  int n_done;

  life_next_gen #(
    .WORDS_PER_ROW(WPR),
    .ROWS(NROWS),
    .ADDR_W(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_addr(out_addr),
    .busy(busy),
    .done(done)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] exp_addr(input int k);
    logic [8:0] r;
    logic [5:0] w;
    r = 9'(k / WPR);
    w = 6'(k % WPR);
    return {9'h000, r, w};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_frames();
    for (int k = 0; k < TOTAL; k++) begin
      img[k]  = 16'h0000;
      expd[k] = 16'h0000;
    end
  endtask

  task automatic set_in(input int row, input int word, input logic [15:0] val);
    img[row*WPR + word] = val;
  endtask

  task automatic set_exp(input int row, input int word, input logic [15:0] val);
    expd[row*WPR + word] = val;
  endtask

  // Runs one generation; abort_after >= 0 returns once that many outputs were taken
  task automatic applyStimulus(input int ready_pct, input int abort_after,
                               output int outs, output int dones);
    int in_idx;
    int out_idx;
    int cycles;
    bit take_in;
    bit take_out;
    bit stalled;
    bit finished;
    logic [15:0] held_d;
    logic [23:0] held_a;
    in_idx   = 0;
    out_idx  = 0;
    cycles   = 0;
    stalled  = 1'b0;
    finished = 1'b0;
    held_d   = '0;
    held_a   = '0;
    dones    = 0;
    in_valid  = 1'b1;
    in_data   = img[0];
    out_ready = ($urandom_range(99) < ready_pct);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!finished && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
      if (stalled) begin
        checkOutput("stall_data", 32'(out_data), 32'(held_d));
        checkOutput("stall_addr", 32'(out_addr), 32'(held_a));
      end
      take_in  = in_valid && in_ready;
      take_out = out_valid && out_ready;
      if (take_out) begin
        if (out_idx < TOTAL) begin
          checkOutput($sformatf("data[%0d]", out_idx), 32'(out_data), 32'(expd[out_idx]));
          checkOutput($sformatf("addr[%0d]", out_idx), 32'(out_addr), 32'(exp_addr(out_idx)));
        end
        out_idx++;
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_a  = out_addr;
      if (done) begin
        dones++;
        finished = 1'b1;
      end
      if (abort_after >= 0 && out_idx >= abort_after) finished = 1'b1;
      if (!finished) begin
        @(posedge clk);
        #1;
        if (take_in) in_idx++;
        in_valid  = (in_idx < TOTAL);
        in_data   = (in_idx < TOTAL) ? img[in_idx] : 16'h0000;
        out_ready = ($urandom_range(99) < ready_pct);
      end
    end
    checkOutput("gen_finished", 32'(finished), 32'd1);
    outs = out_idx;
  endtask

  task automatic post_checks(input string tag, input int outs, input int dones);
    int extra;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checkOutput({tag, "_transfers"}, 32'(outs), 32'(TOTAL));
    checkOutput({tag, "_done_pulses"}, 32'(dones + extra), 32'd1);
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic load_blinker();
    clear_frames();
    set_in(10, 1, 16'h0070);
    set_exp(9, 1, 16'h0020);
    set_exp(10, 1, 16'h0020);
    set_exp(11, 1, 16'h0020);
  endtask

  // Directed sequence of scenarios
  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_addr", 32'(out_addr), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd0);

    $display("[TB] vertical blinker");
    load_blinker();
    applyStimulus(100, -1, n_out, n_done);
    post_checks("blinker", n_out, n_done);

    $display("[TB] cross-word blinker");
    clear_frames();
    set_in(5, 0, 16'h8000);
    set_in(5, 1, 16'h0003);
    set_exp(4, 1, 16'h0001);
    set_exp(5, 1, 16'h0001);
    set_exp(6, 1, 16'h0001);
    applyStimulus(100, -1, n_out, n_done);
    post_checks("crossword", n_out, n_done);

    $display("[TB] corner blocks");
    clear_frames();
    set_in(0, 0, 16'h0003);
    set_in(1, 0, 16'h0003);
    set_in(NROWS-2, WPR-1, 16'hC000);
    set_in(NROWS-1, WPR-1, 16'hC000);
    set_exp(0, 0, 16'h0003);
    set_exp(1, 0, 16'h0003);
    set_exp(NROWS-2, WPR-1, 16'hC000);
    set_exp(NROWS-1, WPR-1, 16'hC000);
    applyStimulus(100, -1, n_out, n_done);
    post_checks("corner", n_out, n_done);

    $display("[TB] backpressure");
    load_blinker();
    applyStimulus(30, -1, n_out, n_done);
    post_checks("backpressure", n_out, n_done);

    $display("[TB] reset during emit");
    load_blinker();
    applyStimulus(100, 20*WPR + 5, n_out, n_done);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    n_done   = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || out_valid) n_done++;
    end
    checkOutput("abort_quiet", 32'(n_done), 32'd0);
    applyStimulus(100, -1, n_out, n_done);
    post_checks("rerun", n_out, n_done);

    $display("[TB] column wrap");
    clear_frames();
    set_in(12, WPR-1, 16'h8000);
    set_in(12, 0, 16'h0003);
`ifdef LIFE_WRAP_EN
    set_exp(11, 0, 16'h0001);
    set_exp(12, 0, 16'h0001);
    set_exp(13, 0, 16'h0001);
`endif
    applyStimulus(100, -1, n_out, n_done);
    post_checks("wrap", n_out, n_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
